// File: rtl/aes_ctr_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_stream_if
// Brief    : Word-in / word-out valid-ready streams of the CTR stream block.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_ctr_stream_if;
   logic        in_valid_i;
   logic [31:0] in_data_i;
   logic        in_ready_o;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_ready_i;

   modport master (
      output in_valid_i, in_data_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o
   );

   modport slave (
      input  in_valid_i, in_data_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o
   );
endinterface
`default_nettype wire

// File: rtl/aes_ctr_stream.sv
`default_nettype none
// ============================================================================
// Module   : aes_ctr_stream
// Brief    : CTR-mode front/back end: packs 4 words, XORs with AES keystream.
// Revision : 1.0 - initial release
// ============================================================================
module aes_ctr_stream #(
   parameter int LATENCY = 21,
   parameter int STAB_W  = 5
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [95:0]       nonce_i,
   input  logic [31:0]       ctr_init_i,
   input  logic              ctr_load_i,
   aes_ctr_stream_if.slave   stream,
   output logic [127:0]      aes_state_o,
   input  logic [127:0]      aes_cipher_i,
   output logic              wrap_o,
   output logic              busy_o
);

   localparam logic [STAB_W-1:0] c_LAT = STAB_W'(LATENCY);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_wcnt;
   logic [1:0]          r_ocnt;
   logic [95:0]         r_nonce;
   logic [31:0]         r_ctr;
   logic [STAB_W-1:0]   r_stab;
   logic                r_wrap;
   logic                r_out_valid;
   logic [127:0]        r_buf;
   logic [127:0]        r_obuf;

   logic                w_in_ready;
   logic                w_load_ok;
   logic                w_word_acc;
   logic                w_capture;
   logic                w_out_acc;
   logic [31:0]         w_out_word;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state <= S_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_load_ok   = 1'b0;
      w_word_acc  = 1'b0;
      w_capture   = 1'b0;
      w_out_acc   = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_in_ready = !ctr_load_i;
            w_load_ok  = ctr_load_i && (r_wcnt == 2'd0);
            w_word_acc = stream.in_valid_i && w_in_ready;
            if (w_word_acc && (r_wcnt == 2'd3)) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            // Keystream is only trusted once {nonce, ctr} has been steady for the full pipe depth
            if (r_stab == c_LAT) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_out_acc = r_out_valid && stream.out_ready_i;
            if (w_out_acc && (r_ocnt == 2'd3)) begin
               w_state_nxt = S_LOAD;
            end
         end
         default: w_state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_wcnt      <= 2'd0;
         r_ocnt      <= 2'd0;
         r_nonce     <= '0;
         r_ctr       <= '0;
         r_stab      <= '0;
         r_wrap      <= 1'b0;
         r_out_valid <= 1'b0;
         r_buf       <= '0;
         r_obuf      <= '0;
      end else begin
         if (w_load_ok) begin
            r_nonce <= nonce_i;
            r_ctr   <= ctr_init_i;
            r_stab  <= '0;
            r_wrap  <= 1'b0;
         end else if (w_capture) begin
            r_ctr  <= r_ctr + 32'd1;
            r_stab <= '0;
            if (r_ctr == 32'hFFFF_FFFF) begin
               r_wrap <= 1'b1;
            end
         end else if (r_stab != c_LAT) begin
            r_stab <= r_stab + STAB_W'(1);
         end

         if (w_word_acc) begin
            r_wcnt <= r_wcnt + 2'd1;
            case (r_wcnt)
               2'd0:    r_buf[127:96] <= stream.in_data_i;
               2'd1:    r_buf[95:64]  <= stream.in_data_i;
               2'd2:    r_buf[63:32]  <= stream.in_data_i;
               default: r_buf[31:0]   <= stream.in_data_i;
            endcase
         end

         if (w_capture) begin
            r_obuf      <= r_buf ^ aes_cipher_i;
            r_out_valid <= 1'b1;
            r_ocnt      <= 2'd0;
         end else if (w_out_acc) begin
            r_ocnt <= r_ocnt + 2'd1;
            if (r_ocnt == 2'd3) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_out_word = r_obuf[31:0];
      case (r_ocnt)
         2'd0:    w_out_word = r_obuf[127:96];
         2'd1:    w_out_word = r_obuf[95:64];
         2'd2:    w_out_word = r_obuf[63:32];
         default: w_out_word = r_obuf[31:0];
      endcase
   end

   assign stream.in_ready_o  = w_in_ready;
   assign stream.out_valid_o = r_out_valid;
   assign stream.out_data_o  = w_out_word;
   assign aes_state_o        = {r_nonce, r_ctr};
   assign wrap_o             = r_wrap;
   assign busy_o             = (r_state != S_LOAD) || (r_wcnt != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_aes_ctr_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_aes_ctr_stream
// Brief    : Randomised bench for aes_ctr_stream with an identity-cipher core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ctr_stream;

   localparam int LATENCY = 21;
   localparam int STAB_W  = 5;

   logic          clk;
   logic          rst;
   logic [95:0]   nonce;
   logic [31:0]   ctr_init;
   logic          ctr_load;
   logic [127:0]  aes_state;
   logic [127:0]  aes_cipher;
   logic          wrap;
   logic          busy;
   logic [127:0]  pipe [LATENCY];

   int            cyc = 0;
   int            n_checks = 0;
   int            n_fail = 0;

   // Reference model: what {nonce, ctr} should be and when it last changed
   logic [95:0]   m_nonce;
   logic [31:0]   m_ctr;
   logic          m_wrap;
   int            t_change;

   aes_ctr_stream_if stream ();

   aes_ctr_stream #(
      .LATENCY (LATENCY),
      .STAB_W  (STAB_W)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .nonce_i      (nonce),
      .ctr_init_i   (ctr_init),
      .ctr_load_i   (ctr_load),
      .stream       (stream),
      .aes_state_o  (aes_state),
      .aes_cipher_i (aes_cipher),
      .wrap_o       (wrap),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      pipe[0] <= aes_state;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign aes_cipher = pipe[LATENCY-1];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_load(input logic [95:0] n, input logic [31:0] c);
      nonce    = n;
      ctr_init = c;
      ctr_load = 1'b1;
      stream.in_valid_i = 1'b0;
      #1;
      check("load_in_ready", stream.in_ready_o, 1'b0);
      @(negedge clk);
      ctr_load = 1'b0;
      m_nonce  = n;
      m_ctr    = c;
      m_wrap   = 1'b0;
      t_change = cyc;
      #1;
      check("load_state", aes_state, {m_nonce, m_ctr});
      check("load_wrap", wrap, m_wrap);
   endtask

   task automatic send_block(input logic [127:0] blk, input int max_gap, input bit load_at2,
                             output int c_w);
      int k;
      int gap;
      c_w = 0;
      for (int i = 0; i < 4; i++) begin
         gap = int'($urandom_range(max_gap, 0));
         repeat (gap) @(negedge clk);
         if (load_at2 && i == 2) begin
            nonce    = {$urandom, $urandom, $urandom};
            ctr_init = $urandom;
            ctr_load = 1'b1;
            #1;
            check("ignored_load_in_ready", stream.in_ready_o, 1'b0);
            @(negedge clk);
            ctr_load = 1'b0;
            #1;
            check("ignored_load_state", aes_state, {m_nonce, m_ctr});
            @(negedge clk);
         end
         stream.in_valid_i = 1'b1;
         stream.in_data_i  = blk[127 - 32*i -: 32];
         #1;
         k = 0;
         while (!stream.in_ready_o && k < 100) begin
            @(negedge clk);
            #1;
            k++;
         end
         check("in_ready", stream.in_ready_o, 1'b1);
         c_w = cyc;
         @(negedge clk);
         stream.in_valid_i = 1'b0;
      end
   endtask

   task automatic pulse_load_in_wait();
      nonce    = {$urandom, $urandom, $urandom};
      ctr_init = $urandom;
      ctr_load = 1'b1;
      #1;
      check("wait_load_in_ready", stream.in_ready_o, 1'b0);
      @(negedge clk);
      ctr_load = 1'b0;
      #1;
      check("wait_load_state", aes_state, {m_nonce, m_ctr});
   endtask

   task automatic recv_block(input logic [127:0] exp, input int exp_cyc, input logic [15:0] stalls);
      int          k;
      logic [31:0] ew;
      k = 0;
      while (!stream.out_valid_o && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("valid_rise_cycle", cyc, exp_cyc);
      for (int i = 0; i < 4; i++) begin
         ew = exp[127 - 32*i -: 32];
         stream.out_ready_i = 1'b0;
         repeat (int'(stalls[4*i +: 4])) begin
            #1;
            check("hold_word", stream.out_data_o, ew);
            check("drain_in_ready", stream.in_ready_o, 1'b0);
            @(negedge clk);
         end
         stream.out_ready_i = 1'b1;
         #1;
         check("out_valid", stream.out_valid_o, 1'b1);
         check("out_word", stream.out_data_o, ew);
         @(negedge clk);
      end
      stream.out_ready_i = 1'b0;
      check("valid_drop", stream.out_valid_o, 1'b0);
      check("busy_idle", busy, 1'b0);
      check("state_after_block", aes_state, {m_nonce, m_ctr});
      check("wrap_flag", wrap, m_wrap);
   endtask

   // Output appears one cycle after the later of: first WAIT cycle, or keystream settled
   task automatic run_block(input logic [127:0] blk, input int max_gap, input bit load_at2,
                            input bit pulse_wait, input logic [15:0] stalls);
      int           c_w;
      int           cap;
      logic [127:0] exp;
      send_block(blk, max_gap, load_at2, c_w);
      cap = (c_w + 1 > t_change + LATENCY) ? c_w + 1 : t_change + LATENCY;
      exp = blk ^ {m_nonce, m_ctr};
      #1;
      check("busy_in_wait", busy, 1'b1);
      if (pulse_wait) pulse_load_in_wait();
      if (m_ctr == 32'hFFFF_FFFF) m_wrap = 1'b1;
      m_ctr    = m_ctr + 32'd1;
      t_change = cap + 1;
      recv_block(exp, cap + 1, stalls);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int           c_w;
      int           gsel;
      int           mg;
      bit           seen;
      logic [31:0]  cinit;

      clk = 1'b0;
      rst = 1'b1;
      nonce = '0;
      ctr_init = '0;
      ctr_load = 1'b0;
      stream.in_valid_i  = 1'b0;
      stream.in_data_i   = '0;
      stream.out_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_nonce = '0;
      m_ctr = '0;
      m_wrap = 1'b0;
      t_change = cyc;
      #1;
      check("rst_in_ready", stream.in_ready_o, 1'b1);
      check("rst_out_valid", stream.out_valid_o, 1'b0);
      check("rst_out_data", stream.out_data_o, 32'h0);
      check("rst_state", aes_state, 128'h0);
      check("rst_wrap", wrap, 1'b0);
      check("rst_busy", busy, 1'b0);
      @(negedge clk);

      // Single block, words sent straight after the load
      do_load(96'h0, 32'h1);
      run_block(128'h11111111_22222222_33333333_44444444, 0, 1'b0, 1'b0, 16'h0);

      // Idle gap: keystream long settled, output 2 cycles after the last word
      do_load(96'h0, 32'h55);
      repeat (30) @(negedge clk);
      run_block(128'h0, 0, 1'b0, 1'b0, 16'h0);

      // Backpressure on word 1
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 16'h0050);

      // Ignored loads at wcnt=2 and during WAIT
      do_load({$urandom, $urandom, $urandom}, $urandom);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1, 1'b1, 16'h0);

      // Counter wrap across two blocks
      do_load({$urandom, $urandom, $urandom}, 32'hFFFF_FFFF);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 16'h0);
      check("wrap_after_block0", wrap, 1'b1);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 16'h0);

      // Reset in the 10th WAIT cycle of a block
      send_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, c_w);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_nonce = '0;
      m_ctr = '0;
      m_wrap = 1'b0;
      t_change = cyc;
      #1;
      check("midrst_out_valid", stream.out_valid_o, 1'b0);
      check("midrst_state", aes_state, 128'h0);
      check("midrst_in_ready", stream.in_ready_o, 1'b1);
      check("midrst_wrap", wrap, 1'b0);
      check("midrst_busy", busy, 1'b0);
      seen = 1'b0;
      stream.out_ready_i = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (stream.out_valid_o) seen = 1'b1;
      end
      stream.out_ready_i = 1'b0;
      check("no_output_after_rst", seen, 1'b0);

      // Wrap set, then cleared by a later load
      do_load({$urandom, $urandom, $urandom}, 32'hFFFF_FFFF);
      run_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b0, 1'b0, 16'h0);
      do_load({$urandom, $urandom, $urandom}, $urandom);

      // Randomised traffic
      for (int it = 0; it < 25; it++) begin
         if ($urandom_range(2, 0) == 0) begin
            cinit = ($urandom_range(1, 0) == 1) ? (32'hFFFF_FFFF - $urandom_range(2, 0)) : $urandom;
            do_load({$urandom, $urandom, $urandom}, cinit);
         end
         gsel = int'($urandom_range(2, 0));
         mg   = (gsel == 0) ? 0 : ((gsel == 1) ? 3 : 30);
         run_block({$urandom, $urandom, $urandom, $urandom}, mg, ($urandom_range(3, 0) == 0),
                   1'b0, 16'($urandom) & 16'h3333);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
